// File: rtl/dsp_mac_slice.sv
// dsp_mac_slice
//   Parametrised DSP MAC slice. It has a pre-adder, a signed multiplier and a
//   post-adder/accumulator, with a valid tag, signed overflow detection and
//   optional saturation. Slices chain through PCIN/PCOUT to build wide filters.
//
//   Pipeline: AREG input stages -> optional MREG product stage -> P register.
//   OPMODE, CARRYIN, C and the valid tag travel with their operands. PCIN is
//   not delayed; it is used directly at the post-adder.
//
// Ports
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   ce_i            global clock enable; 0 freezes every register
//   in_valid_i      operands valid this cycle
//   a_i, b_i, d_i   multiplier / pre-adder operands (signed)
//   c_i, pcin_i     post-adder operand, cascade input
//   opmode_i        [1:0] X, [3:2] Z, [4] pre-add use, [5] carry enable,
//                   [6] pre-sub, [7] post-sub
//   carryin_i       post-adder carry
//   bcout_o         selected multiplier B operand (cascade)
//   m_o             product at the multiplier stage output
//   p_o, pcout_o    result register
//   carryout_o      unsigned carry/borrow out of the post-add
//   overflow_o      signed overflow of the post-add
//   out_valid_o     P holds a result from a valid input
module dsp_mac_slice #(
   parameter int AW     = 18,
   parameter int BW     = 18,
   parameter int PW     = 48,
   parameter int AREG   = 1,
   parameter int MREG   = 1,
   parameter int SAT_EN = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ce_i,
   input  logic              in_valid_i,
   input  logic [AW-1:0]     a_i,
   input  logic [BW-1:0]     b_i,
   input  logic [BW-1:0]     d_i,
   input  logic [PW-1:0]     c_i,
   input  logic [PW-1:0]     pcin_i,
   input  logic [7:0]        opmode_i,
   input  logic              carryin_i,
   output logic [BW-1:0]     bcout_o,
   output logic [AW+BW-1:0]  m_o,
   output logic [PW-1:0]     p_o,
   output logic [PW-1:0]     pcout_o,
   output logic              carryout_o,
   output logic              overflow_o,
   output logic              out_valid_o
);

   localparam int MW = AW + BW;

   typedef struct packed {
      logic          vld;
      logic [7:0]    op;
      logic          cin;
      logic [AW-1:0] a;
      logic [BW-1:0] b;
      logic [BW-1:0] d;
      logic [PW-1:0] c;
   } opnd_t;

   typedef struct packed {
      logic          vld;
      logic [7:0]    op;
      logic          cin;
      logic [MW-1:0] m;
      logic [PW-1:0] c;
   } prod_t;

   // ---------------- stage 0: input registers ----------------
   opnd_t opnd_d, opnd;

   assign opnd_d = {in_valid_i, opmode_i, carryin_i, a_i, b_i, d_i, c_i};

   generate
      if (AREG == 0) begin : g_areg0
         assign opnd = opnd_d;
      end else begin : g_areg
         opnd_t areg_q [AREG];
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int i = 0; i < AREG; i++) areg_q[i] <= '0;
            end else if (ce_i) begin
               areg_q[0] <= opnd_d;
               for (int i = 1; i < AREG; i++) areg_q[i] <= areg_q[i-1];
            end
         end
         assign opnd = areg_q[AREG-1];
      end
   endgenerate

   // ---------------- pre-adder and multiplier ----------------
   logic [BW-1:0]        pre_sum, bsel;
   logic signed [MW-1:0] a_ext, b_ext;
   logic [MW-1:0]        m_d;

   always_comb begin
      pre_sum = opnd.op[6] ? (opnd.d - opnd.b) : (opnd.d + opnd.b);
      bsel    = opnd.op[4] ? pre_sum : opnd.b;
      // Widen both operands first so the low MW product bits are exact.
      a_ext   = MW'($signed(opnd.a));
      b_ext   = MW'($signed(bsel));
      m_d     = a_ext * b_ext;
   end

   assign bcout_o = bsel;

   // ---------------- stage 1: product register ----------------
   prod_t prod_d, prod;

   assign prod_d = {opnd.vld, opnd.op, opnd.cin, m_d, opnd.c};

   generate
      if (MREG == 0) begin : g_mreg0
         assign prod = prod_d;
      end else begin : g_mreg
         prod_t mreg_q;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)    mreg_q <= '0;
            else if (ce_i) mreg_q <= prod_d;
         end
         assign prod = mreg_q;
      end
   endgenerate

   assign m_o = prod.m;

   // ---------------- post-adder ----------------
   logic [PW-1:0] p_q, p_d, x_v, z_v, m_ext;
   logic          cin_eff, ovf_d;
   logic [PW:0]   usum;           // zero-extended sum: bit PW is carry/borrow
   logic [PW+1:0] ssum, xs, zs, cs; // sign-extended sum: exposes overflow

   always_comb begin
      m_ext = {{(PW-MW+1){prod.m[MW-1]}}, prod.m[MW-2:0]};

      x_v = '0;
      case (prod.op[1:0])
         2'd0: x_v = '0;
         2'd1: x_v = m_ext;
         2'd2: x_v = p_q;
         2'd3: x_v = prod.c;
      endcase

      z_v = '0;
      case (prod.op[3:2])
         2'd0: z_v = '0;
         2'd1: z_v = pcin_i;
         2'd2: z_v = p_q;
         2'd3: z_v = prod.c;
      endcase

      cin_eff = prod.cin & prod.op[5];

      if (prod.op[7])
         usum = {1'b0, z_v} - {1'b0, x_v} - {{PW{1'b0}}, cin_eff};
      else
         usum = {1'b0, z_v} + {1'b0, x_v} + {{PW{1'b0}}, cin_eff};

      zs = {{2{z_v[PW-1]}}, z_v};
      xs = {{2{x_v[PW-1]}}, x_v};
      cs = {{(PW+1){1'b0}}, cin_eff};
      ssum = prod.op[7] ? (zs - xs - cs) : (zs + xs + cs);

      // Representable in PW bits only if the top three bits agree.
      ovf_d = (ssum[PW+1:PW-1] != 3'b000) && (ssum[PW+1:PW-1] != 3'b111);

      p_d = usum[PW-1:0];
      if (SAT_EN != 0 && ovf_d)
         p_d = ssum[PW+1] ? {1'b1, {(PW-1){1'b0}}} : {1'b0, {(PW-1){1'b1}}};
   end

   // ---------------- stage 2: result registers ----------------
   logic co_q, ov_q, vld_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p_q   <= '0;
         co_q  <= 1'b0;
         ov_q  <= 1'b0;
         vld_q <= 1'b0;
      end else if (ce_i) begin
         vld_q <= prod.vld;
         // Bubbles flow through the datapath but never disturb P.
         if (prod.vld) begin
            p_q  <= p_d;
            co_q <= usum[PW];
            ov_q <= ovf_d;
         end
      end
   end

   assign p_o         = p_q;
   assign pcout_o     = p_q;
   assign carryout_o  = co_q;
   assign overflow_o  = ov_q;
   assign out_valid_o = vld_q;

endmodule

// File: tb/tb_dsp_mac_slice.sv
module tb_dsp_mac_slice;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ce;
   logic        in_valid;
   logic [17:0] a, b, d;
   logic [47:0] c, pcin;
   logic [7:0]  opmode;
   logic        cin;

   logic [17:0] bc_a, bc_s, bc_b;
   logic [35:0] m_a, m_s, m_b;
   logic [47:0] p_a, p_s, p_b, pc_a, pc_s, pc_b;
   logic        co_a, co_s, co_b, ov_a, ov_s, ov_b, ova, ova_s, ova_b;

   always #5 clk = ~clk;

   // wrap, L=1+1+1
   dsp_mac_slice #(.AW(18), .BW(18), .PW(48), .AREG(1), .MREG(1), .SAT_EN(0)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .ce_i(ce), .in_valid_i(in_valid), .a_i(a), .b_i(b), .d_i(d),
      .c_i(c), .pcin_i(pcin), .opmode_i(opmode), .carryin_i(cin), .bcout_o(bc_a), .m_o(m_a),
      .p_o(p_a), .pcout_o(pc_a), .carryout_o(co_a), .overflow_o(ov_a), .out_valid_o(ova));
   // saturating
   dsp_mac_slice #(.AW(18), .BW(18), .PW(48), .AREG(1), .MREG(1), .SAT_EN(1)) u_dut_s (
      .clk(clk), .rst_n(rst_n), .ce_i(ce), .in_valid_i(in_valid), .a_i(a), .b_i(b), .d_i(d),
      .c_i(c), .pcin_i(pcin), .opmode_i(opmode), .carryin_i(cin), .bcout_o(bc_s), .m_o(m_s),
      .p_o(p_s), .pcout_o(pc_s), .carryout_o(co_s), .overflow_o(ov_s), .out_valid_o(ova_s));
   // wrap, L=2+0+1
   dsp_mac_slice #(.AW(18), .BW(18), .PW(48), .AREG(2), .MREG(0), .SAT_EN(0)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .ce_i(ce), .in_valid_i(in_valid), .a_i(a), .b_i(b), .d_i(d),
      .c_i(c), .pcin_i(pcin), .opmode_i(opmode), .carryin_i(cin), .bcout_o(bc_b), .m_o(m_b),
      .p_o(p_b), .pcout_o(pc_b), .carryout_o(co_b), .overflow_o(ov_b), .out_valid_o(ova_b));

   int checks = 0;
   int fails  = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [7:0]  op;
      logic [17:0] a, b, d;
      logic [47:0] c;
      logic        cin;
   } rec_t;

   function automatic logic signed [63:0] sx18(input logic [17:0] v);
      return {{46{v[17]}}, v};
   endfunction
   function automatic logic signed [63:0] sx48(input logic [47:0] v);
      return {{16{v[47]}}, v};
   endfunction

   function automatic void model(input rec_t r, input logic [47:0] pcin_v, input logic [47:0] pprev,
                                 input bit sat, output logic [47:0] p, output bit co, output bit ov);
      logic [17:0]        pre, bs;
      logic signed [63:0] mv, xv, zv, t, xu, zu, cu, ci;
      logic signed [63:0] maxp, minp;
      maxp = 64'sh0000_7FFF_FFFF_FFFF;
      minp = -maxp - 64'sd1;
      pre = r.op[6] ? (r.d - r.b) : (r.d + r.b);
      bs  = r.op[4] ? pre : r.b;
      mv  = sx18(r.a) * sx18(bs);
      case (r.op[1:0])
         2'd0: xv = 0;
         2'd1: xv = mv;
         2'd2: xv = sx48(pprev);
         default: xv = sx48(r.c);
      endcase
      case (r.op[3:2])
         2'd0: zv = 0;
         2'd1: zv = sx48(pcin_v);
         2'd2: zv = sx48(pprev);
         default: zv = sx48(r.c);
      endcase
      ci = (r.cin && r.op[5]) ? 64'sd1 : 64'sd0;
      t  = r.op[7] ? (zv - xv - ci) : (zv + xv + ci);
      ov = (t > maxp) || (t < minp);
      xu = xv & 64'sh0000_FFFF_FFFF_FFFF;
      zu = zv & 64'sh0000_FFFF_FFFF_FFFF;
      cu = r.op[7] ? (zu - xu - ci) : (zu + xu + ci);
      co = cu[48];
      if (sat && ov) p = (t > 0) ? 48'h7FFF_FFFF_FFFF : 48'h8000_0000_0000;
      else           p = t[47:0];
   endfunction

   rec_t        q[$];
   bit          track = 0;
   logic [47:0] p_mw, p_ms;

   // One clock; outputs are sampled 1 time unit after the edge.
   task automatic tick();
      bit   ce_s, push_s;
      rec_t r, e;
      logic [47:0] ep, eps;
      bit   eco, eov, ecos, eovs;
      ce_s   = ce;
      push_s = ce && in_valid;
      r = '{opmode, a, b, d, c, cin};
      @(posedge clk); #1;
      if (track) begin
         if (push_s) q.push_back(r);
         if (ce_s) begin
            chk("valid_agree_s", {63'd0, ova_s}, {63'd0, ova});
            chk("valid_agree_b", {63'd0, ova_b}, {63'd0, ova});
            if (ova) begin
               if (q.size() == 0) begin
                  checks++; fails++;
                  $display("FAIL spurious_result: got a result with empty model queue");
               end else begin
                  e = q.pop_front();
                  model(e, pcin, p_mw, 1'b0, ep, eco, eov);
                  model(e, pcin, p_ms, 1'b1, eps, ecos, eovs);
                  chk("rnd_p_a", p_a, ep);
                  chk("rnd_co_a", co_a, eco);
                  chk("rnd_ov_a", ov_a, eov);
                  chk("rnd_p_b", p_b, ep);
                  chk("rnd_p_s", p_s, eps);
                  chk("rnd_ov_s", ov_s, eovs);
                  p_mw = ep;
                  p_ms = eps;
               end
            end
         end
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      p_mw = '0;
      p_ms = '0;
   endtask

   task automatic rand_ops(input logic [7:0] opv);
      opmode = opv;
      a = 18'($urandom());
      b = 18'($urandom());
      d = 18'($urandom());
      c = ($urandom_range(0, 3) == 0) ? (48'h7FFF_FFFF_FFF0 + 48'($urandom_range(0, 31)))
                                      : {16'($urandom()), $urandom()};
      cin = 1'($urandom());
   endtask

   // ---------------- directed vectors ----------------
   typedef struct {
      logic [7:0]  op;
      logic [17:0] a, b, d;
      logic [47:0] c, pcin;
      logic        cin;
      logic [47:0] ep, eps;
      logic        eco, eov;
      logic [35:0] em;
      logic [17:0] ebc;
   } vec_t;

   vec_t vt [11];

   initial begin
      vt[0]  = '{8'h55, 18'h3FFFE, 18'd3, 18'd10, 48'd0, 48'd100, 1'b1,
                 48'd86, 48'd86, 1'b1, 1'b0, 36'hF_FFFF_FFF2, 18'd7};
      vt[1]  = '{8'h75, 18'h3FFFE, 18'd3, 18'd10, 48'd0, 48'd100, 1'b1,
                 48'd87, 48'd87, 1'b1, 1'b0, 36'hF_FFFF_FFF2, 18'd7};
      vt[2]  = '{8'h01, 18'd3, 18'd4, 18'd0, 48'd0, 48'd100, 1'b1,
                 48'd12, 48'd12, 1'b0, 1'b0, 36'd12, 18'd4};
      vt[3]  = '{8'h0D, 18'd1, 18'd1, 18'd0, 48'h7FFF_FFFF_FFFF, 48'd0, 1'b0,
                 48'h8000_0000_0000, 48'h7FFF_FFFF_FFFF, 1'b0, 1'b1, 36'd1, 18'd1};
      vt[4]  = '{8'h8D, 18'd3, 18'd4, 18'd0, 48'd5, 48'd0, 1'b0,
                 48'hFFFF_FFFF_FFF9, 48'hFFFF_FFFF_FFF9, 1'b1, 1'b0, 36'd12, 18'd4};
      vt[5]  = '{8'h8D, 18'd1, 18'd1, 18'd0, 48'h8000_0000_0000, 48'd0, 1'b0,
                 48'h7FFF_FFFF_FFFF, 48'h8000_0000_0000, 1'b0, 1'b1, 36'd1, 18'd1};
      vt[6]  = '{8'h11, 18'h3FFFD, 18'h3FFF9, 18'd5, 48'd0, 48'd0, 1'b0,
                 48'd6, 48'd6, 1'b0, 1'b0, 36'd6, 18'h3FFFE};
      vt[7]  = '{8'h11, 18'd1, 18'd1, 18'h1FFFF, 48'd0, 48'd0, 1'b0,
                 48'hFFFF_FFFE_0000, 48'hFFFF_FFFE_0000, 1'b0, 1'b0, 36'hF_FFFE_0000, 18'h20000};
      vt[8]  = '{8'h0C, 18'd2, 18'd2, 18'd0, 48'd123, 48'd0, 1'b0,
                 48'd123, 48'd123, 1'b0, 1'b0, 36'd4, 18'd2};
      vt[9]  = '{8'hA3, 18'd2, 18'd2, 18'd0, 48'd9, 48'd0, 1'b1,
                 48'hFFFF_FFFF_FFF6, 48'hFFFF_FFFF_FFF6, 1'b1, 1'b0, 36'd4, 18'd2};
      vt[10] = '{8'h5D, 18'd5, 18'd9, 18'd2, 48'd1000, 48'd0, 1'b0,
                 48'd965, 48'd965, 1'b1, 1'b0, 36'hF_FFFF_FFDD, 18'h3FFF9};
   end

   // ---------------- main sequence ----------------
   int          nres, extra, sent;
   logic [47:0] res [6];
   logic [47:0] prev_p;
   logic        prev_v;
   bit          iv_s;

   initial begin
      // reset state with live, nonzero inputs
      rst_n = 1'b0; ce = 1'b1; in_valid = 1'b1;
      a = 18'd5; b = 18'd6; d = 18'd7; c = 48'd99; pcin = 48'd11; opmode = 8'h0D; cin = 1'b1;
      #3;
      chk("rst0_p", p_a, 48'd0);
      chk("rst0_valid", {63'd0, ova}, 64'd0);
      chk("rst0_m", m_a, 36'd0);
      chk("rst0_bcout", bc_a, 18'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      in_valid = 1'b0;
      tick(); tick(); tick();

      // table-driven single-beat vectors: latency, value, and hold on bubble
      foreach (vt[i]) begin
         opmode = vt[i].op; a = vt[i].a; b = vt[i].b; d = vt[i].d;
         c = vt[i].c; pcin = vt[i].pcin; cin = vt[i].cin;
         in_valid = 1'b1;
         tick();
         in_valid = 1'b0;
         tick();
         chk($sformatf("v%0d_early_valid", i), {63'd0, ova}, 64'd0);
         tick();
         chk($sformatf("v%0d_valid", i), {63'd0, ova}, 64'd1);
         chk($sformatf("v%0d_p", i), p_a, vt[i].ep);
         chk($sformatf("v%0d_pcout", i), pc_a, vt[i].ep);
         chk($sformatf("v%0d_carry", i), {63'd0, co_a}, {63'd0, vt[i].eco});
         chk($sformatf("v%0d_ovf", i), {63'd0, ov_a}, {63'd0, vt[i].eov});
         chk($sformatf("v%0d_m", i), m_a, vt[i].em);
         chk($sformatf("v%0d_bcout", i), bc_a, vt[i].ebc);
         chk($sformatf("v%0d_p_sat", i), p_s, vt[i].eps);
         chk($sformatf("v%0d_ovf_sat", i), {63'd0, ov_s}, {63'd0, vt[i].eov});
         chk($sformatf("v%0d_p_areg2", i), p_b, vt[i].ep);
         tick();
         chk($sformatf("v%0d_bubble_valid", i), {63'd0, ova}, 64'd0);
         chk($sformatf("v%0d_bubble_hold", i), p_a, vt[i].ep);
      end

      // MAC accumulate: 4 beats of 3*4 onto P
      do_reset();
      opmode = 8'h09; a = 18'd3; b = 18'd4; d = 18'd0; c = 48'd0; cin = 1'b0;
      in_valid = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         if (k == 5) in_valid = 1'b0;
         tick();
         chk($sformatf("mac_valid_%0d", k), {63'd0, ova}, (k >= 3 && k <= 6) ? 64'd1 : 64'd0);
         chk($sformatf("mac_p_%0d", k), p_a, (k < 3) ? 48'd0 : 48'(12 * ((k - 2) > 4 ? 4 : (k - 2))));
      end

      // async reset mid-pipeline
      opmode = 8'h0D; a = 18'd7; b = 18'd9; c = 48'd1234; in_valid = 1'b1;
      tick(); tick();
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_p_a", p_a, 48'd0);           chk("arst_pc_a", pc_a, 48'd0);
      chk("arst_m_a", m_a, 36'd0);           chk("arst_bc_a", bc_a, 18'd0);
      chk("arst_co_a", {63'd0, co_a}, 64'd0); chk("arst_ov_a", {63'd0, ov_a}, 64'd0);
      chk("arst_v_a", {63'd0, ova}, 64'd0);
      chk("arst_p_s", p_s, 48'd0);           chk("arst_pc_s", pc_s, 48'd0);
      chk("arst_m_s", m_s, 36'd0);           chk("arst_bc_s", bc_s, 18'd0);
      chk("arst_co_s", {63'd0, co_s}, 64'd0); chk("arst_ov_s", {63'd0, ov_s}, 64'd0);
      chk("arst_v_s", {63'd0, ova_s}, 64'd0);
      chk("arst_p_b", p_b, 48'd0);           chk("arst_pc_b", pc_b, 48'd0);
      chk("arst_m_b", m_b, 36'd0);           chk("arst_bc_b", bc_b, 18'd0);
      chk("arst_co_b", {63'd0, co_b}, 64'd0); chk("arst_ov_b", {63'd0, ov_b}, 64'd0);
      chk("arst_v_b", {63'd0, ova_b}, 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      in_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk($sformatf("post_rst_idle_%0d", k), {63'd0, ova}, 64'd0);
      end
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("post_rst_l1", {63'd0, ova}, 64'd0);
      tick();
      chk("post_rst_l2", {63'd0, ova}, 64'd0);
      tick();
      chk("post_rst_l3", {63'd0, ova}, 64'd1);
      chk("post_rst_p", p_a, 48'd1297);   // 1234 + 7*9

      // stall: 6 accumulate beats, CE low for 5 cycles mid-stream
      do_reset();
      opmode = 8'h09; b = 18'd1; c = 48'd0;
      nres = 0; sent = 0;
      for (int cyc = 0; cyc < 40 && nres < 6; cyc++) begin
         ce = !(cyc >= 3 && cyc < 8);
         in_valid = (sent < 6);
         a = 18'(sent + 1);
         iv_s = ce && in_valid;
         prev_p = p_a; prev_v = ova;
         tick();
         if (iv_s) sent++;
         if (!ce) begin
            chk($sformatf("stall_p_%0d", cyc), p_a, prev_p);
            chk($sformatf("stall_v_%0d", cyc), {63'd0, ova}, {63'd0, prev_v});
         end else if (ova) begin
            res[nres] = p_a;
            nres++;
         end
      end
      ce = 1'b1; in_valid = 1'b0;
      chk("stall_count", 64'(nres), 64'd6);
      for (int k = 0; k < 6; k++)
         chk($sformatf("stall_res_%0d", k), (k < nres) ? res[k] : 48'hDEAD, 48'((k + 1) * (k + 2) / 2));
      extra = 0;
      for (int k = 0; k < 4; k++) begin
         tick();
         if (ova) extra++;
      end
      chk("stall_no_dup", 64'(extra), 64'd0);

      // opmode switching every cycle against the model
      do_reset();
      pcin = {16'($urandom()), $urandom()};
      q.delete();
      track = 1;
      for (int k = 0; k < 30; k++) begin
         rand_ops((k % 3 == 0) ? 8'h01 : (k % 3 == 1) ? 8'h0D : 8'h8D);
         in_valid = 1'b1;
         tick();
      end
      in_valid = 1'b0;
      for (int k = 0; k < 6; k++) tick();
      chk("opm_drain", 64'(q.size()), 64'd0);

      // fully random opmode, valid and CE
      pcin = {16'($urandom()), $urandom()};
      for (int k = 0; k < 300; k++) begin
         rand_ops(8'($urandom()));
         in_valid = 1'($urandom());
         ce = ($urandom_range(0, 3) != 0);
         tick();
      end
      ce = 1'b1; in_valid = 1'b0;
      for (int k = 0; k < 6; k++) tick();
      chk("rnd_drain", 64'(q.size()), 64'd0);
      track = 0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      fails++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $fatal(1, "timeout");
   end

endmodule
